// File: rtl/axi_burst_mem_responder_if.sv
// rtl/axi_burst_mem_responder_if.sv - AW/W/B/AR/R bus bundle for the burst memory responder
interface axi_burst_mem_responder_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;

  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   wid;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wlast;

  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;

  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awid, awaddr, awlen, input awready,
    output wvalid, wid, wdata, wlast, input wready,
    input bvalid, bid, bresp, output bready,
    output arvalid, arid, araddr, arlen, input arready,
    input rvalid, rid, rdata, rlast, rresp, output rready
  );

  modport slave (
    input awvalid, awid, awaddr, awlen, output awready,
    input wvalid, wid, wdata, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input arvalid, arid, araddr, arlen, output arready,
    output rvalid, rid, rdata, rlast, rresp, input rready
  );
endinterface

// File: rtl/axi_burst_mem_responder.sv
// rtl/axi_burst_mem_responder.sv - single-outstanding burst slave backed by a word-wide SRAM
module axi_burst_mem_responder #(
  parameter int MEM_INDEX_WIDTH = 16,
  parameter int READ_LATENCY    = 2,
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axi_burst_mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << MEM_INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_WAIT, RD_DATA} state_t;
  state_t state, next_state;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [ID_WIDTH-1:0]        id_q;
  logic [MEM_INDEX_WIDTH-1:0] addr_q;     // word index of the current beat
  logic [7:0]                 last_idx;   // beat index of the final beat (LEN=0 behaves as one beat)
  logic [7:0]                 beat_cnt;
  logic                       err_q;
  logic [3:0]                 lat_cnt;
  logic [DATA_WIDTH-1:0]      rdata_q;

  logic                       awready, wready, bvalid, arready, rvalid;
  logic                       aw_hs, w_hs, b_hs, ar_hs, r_hs, last_beat;
  logic [7:0]                 req_len;
  logic [MEM_INDEX_WIDTH-1:0] aw_word, ar_word, rd_ptr;
  logic                       rd_load;
  logic                       unused_bits;

  assign aw_word   = bus.awaddr[MEM_INDEX_WIDTH+1:2];
  assign ar_word   = bus.araddr[MEM_INDEX_WIDTH+1:2];
  assign req_len   = aw_hs ? bus.awlen : bus.arlen;
  assign last_beat = (beat_cnt == last_idx);
  assign aw_hs     = bus.awvalid && awready;
  assign ar_hs     = bus.arvalid && arready;
  assign w_hs      = bus.wvalid && wready;
  assign b_hs      = bvalid && bus.bready;
  assign r_hs      = rvalid && bus.rready;

  assign unused_bits = ^{bus.wid, bus.awaddr[ADDR_WIDTH-1:MEM_INDEX_WIDTH+2], bus.awaddr[1:0],
                         bus.araddr[ADDR_WIDTH-1:MEM_INDEX_WIDTH+2], bus.araddr[1:0]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: one burst at a time, write wins a same-cycle address tie
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (aw_hs)      next_state = WR_DATA;
        else if (ar_hs) next_state = (READ_LATENCY == 1) ? RD_DATA : RD_WAIT;
      end
      WR_DATA: if (w_hs && last_beat)  next_state = WR_RESP;
      WR_RESP: if (b_hs)               next_state = IDLE;
      RD_WAIT: if (lat_cnt == 4'd1)    next_state = RD_DATA;
      RD_DATA: if (r_hs && last_beat)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; readies held low while in reset
  always_comb begin
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    case (state)
      IDLE: begin
        awready = rst_n;
        arready = rst_n && !bus.awvalid;
      end
      WR_DATA: wready = 1'b1;
      WR_RESP: bvalid = 1'b1;
      RD_DATA: rvalid = 1'b1;
      default: ;
    endcase
  end

  assign bus.awready = awready;
  assign bus.arready = arready;
  assign bus.wready  = wready;
  assign bus.bvalid  = bvalid;
  assign bus.bid     = id_q;
  assign bus.bresp   = (bvalid && err_q) ? 2'b10 : 2'b00;
  assign bus.rvalid  = rvalid;
  assign bus.rid     = id_q;
  assign bus.rdata   = rdata_q;
  assign bus.rlast   = rvalid && last_beat;
  assign bus.rresp   = (rvalid && err_q) ? 2'b10 : 2'b00;

  // Burst bookkeeping: capture on address handshake, advance on every data beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q     <= '0;
      addr_q   <= '0;
      last_idx <= 8'd0;
      beat_cnt <= 8'd0;
      err_q    <= 1'b0;
      lat_cnt  <= 4'd0;
    end else begin
      if (aw_hs || ar_hs) begin
        id_q     <= aw_hs ? bus.awid : bus.arid;
        addr_q   <= aw_hs ? aw_word : ar_word;
        last_idx <= (req_len == 8'd0) ? 8'd0 : req_len - 8'd1;
        err_q    <= (req_len == 8'd0);
        beat_cnt <= 8'd0;
        lat_cnt  <= 4'(READ_LATENCY - 1);
      end
      if (w_hs || r_hs) begin
        addr_q   <= addr_q + MEM_INDEX_WIDTH'(1);
        beat_cnt <= beat_cnt + 8'd1;
      end
      if (w_hs && (bus.wlast != last_beat)) err_q <= 1'b1;
      if (state == RD_WAIT) lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // Read-port address: beat 0 when entering RD_DATA, the following word on each accepted beat
  always_comb begin
    rd_load = 1'b0;
    rd_ptr  = addr_q;
    case (state)
      IDLE: begin
        rd_load = ar_hs && (READ_LATENCY == 1);
        rd_ptr  = ar_word;
      end
      RD_WAIT: rd_load = (lat_cnt == 4'd1);
      RD_DATA: begin
        rd_load = r_hs && !last_beat;
        rd_ptr  = addr_q + MEM_INDEX_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // SRAM write port: contents are never reset
  always_ff @(posedge clk) begin
    if (rst_n && w_hs) mem[addr_q] <= bus.wdata;
  end

  // SRAM registered read port driving RDATA
  always_ff @(posedge clk) begin
    if (!rst_n)       rdata_q <= '0;
    else if (rd_load) rdata_q <= mem[rd_ptr];
  end
endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// tb/tb_axi_burst_mem_responder.sv - directed bench with a word-array memory model and R-channel scoreboard
module tb_axi_burst_mem_responder;
  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MIW   = 16;
  localparam int RL    = 2;
  localparam int DEPTH = 1 << MIW;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
    logic [1:0]  resp;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] mmem [int];
  beat_t       exp_q [$];
  logic [31:0] got_q [$];

  always #5 clk = ~clk;

  axi_burst_mem_responder_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_burst_mem_responder #(
    .MEM_INDEX_WIDTH(MIW), .READ_LATENCY(RL), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Scoreboard: every cycle with RVALID, the beat on the bus must be the oldest expected one
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rvalid) begin
        if (exp_q.size() == 0) begin
          fail_now("r_unexpected_beat");
        end else begin
          check("rdata", bus.rdata, exp_q[0].data);
          check("rid",   bus.rid,   exp_q[0].id);
          check("rlast", bus.rlast, exp_q[0].last);
          check("rresp", bus.rresp, exp_q[0].resp);
          if (bus.rready) begin
            got_q.push_back(bus.rdata);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("rlast_idle", bus.rlast, 1'b0);
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input int wlast_beat, input int bdelay, input logic [31:0] seed);
    int eff = (len == 0) ? 1 : len;
    int base = int'(addr >> 2) % DEPTH;
    logic [1:0] eresp = (len == 0 || wlast_beat != eff) ? 2'b10 : 2'b00;
    int n;
    bit ok;
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len[7:0]; bus.awid = id;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.awready;
      if (bus.arvalid) check("tie_arready_aw", bus.arready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    bus.awvalid = 1'b0;
    if (!ok) begin fail_now("aw_timeout"); return; end
    for (int k = 0; k < eff; k++) begin
      bus.wvalid = 1'b1; bus.wdata = seed + 32'(k); bus.wlast = (k + 1 == wlast_beat); bus.wid = id;
      n = 0; ok = 1'b0;
      while (!ok && n < 50) begin
        @(negedge clk);
        ok = bus.wready;
        if (bus.arvalid) check("tie_arready_w", bus.arready, 1'b0);
        @(posedge clk); #1;
        n++;
      end
      if (!ok) fail_now("w_timeout");
      mmem[(base + k) % DEPTH] = seed + 32'(k);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    repeat (bdelay) begin
      @(negedge clk);
      check("b_hold_valid", bus.bvalid, 1'b1);
      check("b_hold_resp", bus.bresp, eresp);
      check("b_hold_id", bus.bid, id);
      if (bus.arvalid) check("tie_arready_b", bus.arready, 1'b0);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.bvalid;
      if (ok) begin
        check("bresp", bus.bresp, eresp);
        check("bid", bus.bid, id);
      end
      if (bus.arvalid) check("tie_arready_bh", bus.arready, 1'b0);
      @(posedge clk); #1;
      n++;
    end
    bus.bready = 1'b0;
    if (!ok) begin fail_now("b_timeout"); return; end
    if (!bus.arvalid) begin
      @(negedge clk);
      check("b_drop", bus.bvalid, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id, input int pattern);
    int eff = (len == 0) ? 1 : len;
    int base = int'(addr >> 2) % DEPTH;
    int n, i, first;
    bit ok, done;
    beat_t b;
    for (int k = 0; k < eff; k++) begin
      b.data = mmem[(base + k) % DEPTH];
      b.id   = id;
      b.last = (k == eff - 1);
      b.resp = (len == 0) ? 2'b10 : 2'b00;
      exp_q.push_back(b);
    end
    bus.rready = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len[7:0]; bus.arid = id;
    n = 0; ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = bus.arready;
      @(posedge clk); #1;
      n++;
    end
    bus.arvalid = 1'b0;
    if (!ok) begin fail_now("ar_timeout"); exp_q.delete(); return; end
    i = 0; first = -1; done = 1'b0;
    while (!done && i < 500) begin
      if (i > 0) begin @(posedge clk); #1; end
      i++;
      bus.rready = (pattern == 0) || (i % 3 == 1);
      @(negedge clk);
      if (first < 0 && bus.rvalid) first = i;
      if (bus.rvalid && bus.rready && bus.rlast) done = 1'b1;
    end
    if (!done) begin
      fail_now("rd_timeout");
    end else begin
      @(negedge clk);
      check("rd_end_rvalid", bus.rvalid, 1'b0);
      check("rd_latency", 64'(first), 64'(RL));
      check("rd_all_beats", 64'(exp_q.size()), 64'd0);
    end
    exp_q.delete();
    bus.rready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
    bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wlast = 0;
    bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0;
    bus.rready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rlast", bus.rlast, 1'b0);
    check("rst_bresp", bus.bresp, 2'b00);
    check("rst_rresp", bus.rresp, 2'b00);
    check("rst_bid", bus.bid, 4'h0);
    check("rst_rid", bus.rid, 4'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Preload A0..A3 at word 0x40, then burst-read them back
    do_write(32'h100, 4, 4'h1, 4, 0, 32'hA0);
    got_q.delete();
    do_read(32'h100, 4, 4'h1, 0);
    check("lit_rd_count", 64'(got_q.size()), 64'd4);
    check("lit_rd0", got_q[0], 32'hA0);
    check("lit_rd1", got_q[1], 32'hA1);
    check("lit_rd2", got_q[2], 32'hA2);
    check("lit_rd3", got_q[3], 32'hA3);

    // Write 1..4 with BREADY held off 3 cycles, read back under RREADY backpressure
    do_write(32'h200, 4, 4'h2, 4, 3, 32'h1);
    got_q.delete();
    do_read(32'h200, 4, 4'h6, 1);
    check("lit_bp_count", 64'(got_q.size()), 64'd4);
    check("lit_bp0", got_q[0], 32'h1);
    check("lit_bp3", got_q[3], 32'h4);

    // AW/AR tie: write served first, AR held off until the response completes
    bus.arvalid = 1'b1; bus.araddr = 32'h200; bus.arlen = 8'd4; bus.arid = 4'h7;
    do_write(32'h300, 2, 4'h5, 2, 1, 32'h50);
    got_q.delete();
    do_read(32'h200, 4, 4'h7, 0);
    check("lit_tie1", got_q[1], 32'h2);

    // Illegal LEN=0 read: single beat, SLVERR
    got_q.delete();
    do_read(32'h100, 0, 4'h3, 0);
    check("lit_len0_count", 64'(got_q.size()), 64'd1);
    check("lit_len0_data", got_q[0], 32'hA0);

    // Early WLAST: all four beats still land, BRESP SLVERR
    do_write(32'h400, 4, 4'h9, 2, 0, 32'h70);
    got_q.delete();
    do_read(32'h400, 4, 4'h9, 1);
    check("lit_err_w3", got_q[3], 32'h73);

    // Wrap at the top word
    do_write(32'h3FFFC, 2, 4'h1, 2, 0, 32'hC0);
    got_q.delete();
    do_read(32'h3FFFC, 2, 4'h1, 0);
    check("lit_wrap0", got_q[0], 32'hC0);
    check("lit_wrap1", got_q[1], 32'hC1);
    got_q.delete();
    do_read(32'h0, 1, 4'h2, 0);
    check("lit_wrap_word0", got_q[0], 32'hC1);

    // Reset in the middle of RD_DATA
    begin
      int n;
      beat_t b;
      for (int k = 0; k < 4; k++) begin
        b.data = mmem[32'h80 + k]; b.id = 4'h3; b.last = (k == 3); b.resp = 2'b00;
        exp_q.push_back(b);
      end
      bus.rready = 1'b0;
      bus.arvalid = 1'b1; bus.araddr = 32'h200; bus.arlen = 8'd4; bus.arid = 4'h3;
      @(negedge clk);
      check("mid_arready", bus.arready, 1'b1);
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.rvalid && n < 20);
      if (!bus.rvalid) fail_now("mid_rvalid_timeout");
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_rvalid", bus.rvalid, 1'b0);
      check("mid_rst_arready", bus.arready, 1'b0);
      check("mid_rst_rdata", bus.rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_post_arready", bus.arready, 1'b1);
      check("mid_post_rvalid", bus.rvalid, 1'b0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
